bus_sw: RTL and testbench

BUS_SW -- requirements
Module: bus_sw

---
 rtl/bus_sw.sv | 152 +++++++++++++++
 tb/tb_bus_sw.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_sw.sv
// bus_sw: CPU bus switch. Decodes the CPU word address onto a set of slave windows and
// forwards strobe, ack and read data. Unmapped accesses and slave timeouts end with a
// one-cycle error ack. The cause and address of the last error are kept in sticky registers.
module bus_sw #(
   parameter int unsigned         NSLV     = 4,
   parameter logic [22*NSLV-1:0]  SLV_BASE = {22'h3FF800, 22'h3FF7F0, 22'h3F8000, 22'h000000},
   parameter logic [22*NSLV-1:0]  SLV_MASK = {22'h3FFE00, 22'h3FFFF0, 22'h3F8000, 22'h300000},
   parameter int unsigned         TMO      = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                bus_stb,
   input  logic [23:2]         bus_addr,
   output logic [31:0]         bus_din,
   output logic                bus_ack,
   output logic                bus_err,
   output logic [NSLV-1:0]     s_stb,
   input  logic [32*NSLV-1:0]  s_dout,
   input  logic [NSLV-1:0]     s_ack,
   output logic [1:0]          err_cause,
   output logic [23:2]         err_addr
);

   typedef enum logic [1:0] {StIdle, StAct, StErr} state_e;

   state_e       state_q, state_d;
   logic [7:0]   cnt_q, cnt_d;
   logic [2:0]   sel_q, sel_d;
   logic [1:0]   err_cause_q, err_cause_d;
   logic [23:2]  err_addr_q, err_addr_d;

   logic         any_hit;
   logic [2:0]   hit_idx;
   logic [2:0]   cur_idx;
   logic         cur_ack;
   logic [31:0]  cur_dout;
   logic [NSLV-1:0] cur_oh;

   // Address decode; scanning downwards lets the lowest matching window win.
   always_comb begin
      any_hit = 1'b0;
      hit_idx = '0;
      for (int i = int'(NSLV) - 1; i >= 0; i--) begin
         if ((bus_addr & SLV_MASK[22*i +: 22]) == SLV_BASE[22*i +: 22]) begin
            any_hit = 1'b1;
            hit_idx = 3'(i);
         end
      end
   end

   // Slave-side mux: the latched slave once active, the decoded slave while idle.
   always_comb begin
      cur_idx  = (state_q == StAct) ? sel_q : hit_idx;
      cur_ack  = 1'b0;
      cur_dout = '0;
      cur_oh   = '0;
      for (int i = 0; i < int'(NSLV); i++) begin
         if (3'(i) == cur_idx) begin
            cur_ack   = s_ack[i];
            cur_dout  = s_dout[32*i +: 32];
            cur_oh[i] = 1'b1;
         end
      end
   end

   // Next-state and bus outputs; reset forces every output low.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      sel_d       = sel_q;
      err_cause_d = err_cause_q;
      err_addr_d  = err_addr_q;
      s_stb       = '0;
      bus_ack     = 1'b0;
      bus_err     = 1'b0;
      bus_din     = '0;
      case (state_q)
         StIdle: begin
            if (bus_stb) begin
               if (any_hit) begin
                  s_stb = cur_oh;
                  if (cur_ack) begin
                     // Zero-wait access completes without leaving idle.
                     bus_ack = 1'b1;
                     bus_din = cur_dout;
                  end else begin
                     state_d = StAct;
                     sel_d   = hit_idx;
                     cnt_d   = 8'd1;
                  end
               end else begin
                  state_d     = StErr;
                  err_cause_d = 2'b01;
                  err_addr_d  = bus_addr;
               end
            end
         end
         StAct: begin
            if (!bus_stb) begin
               // CPU abort: drop the strobe silently.
               state_d = StIdle;
            end else begin
               s_stb = cur_oh;
               if (cur_ack) begin
                  bus_ack = 1'b1;
                  bus_din = cur_dout;
                  state_d = StIdle;
               end else if (cnt_q == 8'(TMO - 1)) begin
                  state_d     = StErr;
                  err_cause_d = 2'b10;
                  err_addr_d  = bus_addr;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
         end
         StErr: begin
            bus_ack = 1'b1;
            bus_err = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
      if (rst) begin
         s_stb   = '0;
         bus_ack = 1'b0;
         bus_err = 1'b0;
         bus_din = '0;
      end
   end

   // State, counter, selection and sticky error registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         sel_q       <= '0;
         err_cause_q <= '0;
         err_addr_q  <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sel_q       <= sel_d;
         err_cause_q <= err_cause_d;
         err_addr_q  <= err_addr_d;
      end
   end

   assign err_cause = err_cause_q;
   assign err_addr  = err_addr_q;

endmodule

// File: tb/tb_bus_sw.sv
// tb_bus_sw: transaction-level checks of bus_sw against a window/latency model.
module tb_bus_sw;

   localparam int TMO   = 16;
   localparam int NEVER = 1000;

   // Window table, slave 0 first.
   localparam logic [21:0] WBASE [4] = '{22'h000000, 22'h3F8000, 22'h3FF7F0, 22'h3FF800};
   localparam logic [21:0] WMASK [4] = '{22'h300000, 22'h3F8000, 22'h3FFFF0, 22'h3FFE00};

   logic          clk;
   logic          rst;
   logic          bus_stb;
   logic [23:2]   bus_addr;
   logic [31:0]   bus_din;
   logic          bus_ack;
   logic          bus_err;
   logic [3:0]    s_stb;
   logic [127:0]  s_dout;
   logic [3:0]    s_ack;
   logic [1:0]    err_cause;
   logic [23:2]   err_addr;

   int            n_checks;
   int            n_bad;
   logic [1:0]    exp_cause;
   logic [21:0]   exp_eaddr;

   bus_sw #(
      .NSLV (4),
      .TMO  (TMO)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .bus_stb   (bus_stb),
      .bus_addr  (bus_addr),
      .bus_din   (bus_din),
      .bus_ack   (bus_ack),
      .bus_err   (bus_err),
      .s_stb     (s_stb),
      .s_dout    (s_dout),
      .s_ack     (s_ack),
      .err_cause (err_cause),
      .err_addr  (err_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // First matching window, or -1 when the address is unmapped.
   function automatic int model_target(input logic [21:0] a);
      for (int i = 0; i < 4; i++) begin
         if ((a & WMASK[i]) == WBASE[i]) return i;
      end
      return -1;
   endfunction

   // Sample all outputs mid-cycle against the expected values.
   task automatic check_cycle(input logic [3:0] e_stb, input logic e_ack, input logic e_err,
                              input logic [31:0] e_din);
      @(negedge clk);
      check("s_stb", 32'(s_stb), 32'(e_stb));
      check("bus_ack", 32'(bus_ack), 32'(e_ack));
      check("bus_err", 32'(bus_err), 32'(e_err));
      check("bus_din", bus_din, e_din);
      check("err_cause", 32'(err_cause), 32'(exp_cause));
      check("err_addr", 32'(err_addr), 32'(exp_eaddr));
   endtask

   // Start a new cycle: new random read data and ack noise on the non-targeted slaves.
   task automatic drive(input logic stb, input logic [21:0] a, input int h, input logic hack);
      logic [3:0] noise;
      @(posedge clk);
      #1;
      bus_stb  = stb;
      bus_addr = a;
      s_dout   = {$urandom, $urandom, $urandom, $urandom};
      noise    = 4'($urandom);
      if (h >= 0) begin
         noise[h] = hack;
      end
      s_ack = noise;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         drive(1'b0, 22'($urandom), -1, 1'b0);
         check_cycle(4'b0, 1'b0, 1'b0, 32'h0);
      end
   endtask

   // One CPU access: the target slave acks in cycle ack_at (counted from the first strobe
   // cycle), the CPU drops its strobe in cycle drop_at.
   task automatic access(input logic [21:0] a, input int ack_at, input int drop_at);
      int h;
      h = model_target(a);
      if (h < 0) begin
         drive(1'b1, a, -1, 1'b0);
         check_cycle(4'b0, 1'b0, 1'b0, 32'h0);
         drive(1'b1, a, -1, 1'b0);
         exp_cause = 2'b01;
         exp_eaddr = a;
         check_cycle(4'b0, 1'b1, 1'b1, 32'h0);
         return;
      end
      for (int k = 0; k < TMO; k++) begin
         drive(k < drop_at, a, h, k == ack_at);
         if (k == drop_at) begin
            check_cycle(4'b0, 1'b0, 1'b0, 32'h0);
            return;
         end else if (k == ack_at) begin
            check_cycle(4'(1 << h), 1'b1, 1'b0, s_dout[32*h +: 32]);
            return;
         end else begin
            check_cycle(4'(1 << h), 1'b0, 1'b0, 32'h0);
         end
      end
      // No ack within TMO strobe cycles: one error-ack cycle follows.
      drive(1'b1, a, h, 1'b0);
      exp_cause = 2'b10;
      exp_eaddr = a;
      check_cycle(4'b0, 1'b1, 1'b1, 32'h0);
   endtask

   initial begin
      logic [21:0] a;
      int          ack_at;
      int          drop_at;
      n_checks  = 0;
      n_bad     = 0;
      exp_cause = 2'b00;
      exp_eaddr = '0;
      rst       = 1'b1;
      bus_stb   = 1'b1;
      bus_addr  = 22'h000100;
      s_dout    = '0;
      s_ack     = 4'hF;

      // Reset held with a strobe pending: everything stays quiet.
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 22'h000100, 0, 1'b1);
         check_cycle(4'b0, 1'b0, 1'b0, 32'h0);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus_stb = 1'b0;
      idle_cycles(1);

      // 3FF800 also lies in slave 1's window; the lowest-index rule selects slave 1.
      access(22'h3FF800, 0, NEVER);
      idle_cycles(1);
      access(22'h000100, 2, NEVER);
      idle_cycles(1);
      access(22'h200000, NEVER, NEVER);
      idle_cycles(1);
      access(22'h3F8000, NEVER, NEVER);
      idle_cycles(1);
      // Abort after three wait cycles; err_cause keeps the timeout.
      access(22'h000100, NEVER, 4);
      idle_cycles(1);
      // Back-to-back accesses with the strobe held high throughout.
      access(22'h3F8123, 1, NEVER);
      access(22'h100000, NEVER, NEVER);
      access(22'h000004, 0, NEVER);

      // Reset while waiting with cnt at 5 (sixth strobe cycle).
      for (int k = 0; k < 5; k++) begin
         drive(1'b1, 22'h3F8010, 1, 1'b0);
         check_cycle(4'b0010, 1'b0, 1'b0, 32'h0);
      end
      drive(1'b1, 22'h3F8010, 1, 1'b1);
      rst = 1'b1;
      check_cycle(4'b0, 1'b0, 1'b0, 32'h0);
      drive(1'b0, 22'h3F8010, -1, 1'b0);
      rst = 1'b0;
      exp_cause = 2'b00;
      exp_eaddr = '0;
      check_cycle(4'b0, 1'b0, 1'b0, 32'h0);
      access(22'h3F8010, 3, NEVER);
      idle_cycles(1);

      // Randomized traffic across all windows and the unmapped space.
      for (int t = 0; t < 200; t++) begin
         case ($urandom_range(0, 3))
            0: a = 22'($urandom);
            1: a = {7'h7F, 15'($urandom)};
            2: a = {2'b00, 20'($urandom)};
            default: a = {12'h3FF, 10'($urandom_range(0, 1023))};
         endcase
         ack_at  = $urandom_range(0, TMO + 2);
         drop_at = ($urandom_range(0, 4) == 0) ? $urandom_range(1, TMO) : NEVER;
         access(a, ack_at, drop_at);
         idle_cycles($urandom_range(0, 2));
      end

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule
